// File: rtl/jpeg_pkg.sv
// jpeg_pkg: zigzag scan order, JPEG quantizer reciprocals round(65536/Q) and shared types.
package jpeg_pkg;
  typedef logic bank_t;
  typedef logic [5:0] idx_t;
  typedef enum logic {W_IDLE, W_ROWS} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;
  localparam idx_t ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  localparam logic [15:0] RECIP_LUMA [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662};
  localparam logic [15:0] RECIP_CHROMA [64] = '{
    3855, 3641, 2731, 1394,  662,  662,  662,  662,
    3641, 3121, 2521,  993,  662,  662,  662,  662,
    2731, 2521, 1170,  662,  662,  662,  662,  662,
    1394,  993,  662,  662,  662,  662,  662,  662,
     662,  662,  662,  662,  662,  662,  662,  662,
     662,  662,  662,  662,  662,  662,  662,  662,
     662,  662,  662,  662,  662,  662,  662,  662,
     662,  662,  662,  662,  662,  662,  662,  662};
endpackage

// File: rtl/quant_coef.sv
// quant_coef: combinational sign-symmetric reciprocal quantizer with saturation for one coefficient.
module quant_coef #(
  parameter int PIX_OUT_WIDTH = 32,
  parameter int QUANT_WIDTH = 12,
  parameter int RECIP_WIDTH = 16
) (
  input  logic [PIX_OUT_WIDTH-1:0] i_coef,
  input  logic [RECIP_WIDTH-1:0]   i_recip,
  output logic [QUANT_WIDTH-1:0]   o_q
);
  localparam int PW = PIX_OUT_WIDTH + RECIP_WIDTH;
  localparam int RW = PW - 16;
  localparam logic [RW-1:0] MAXP = RW'((1 << (QUANT_WIDTH - 1)) - 1);
  localparam logic [RW-1:0] MAXN = MAXP + 1'b1;
  logic                     w_neg;
  logic [PIX_OUT_WIDTH-1:0] w_mag;
  logic [RW-1:0]            w_rnd;
  assign w_neg = i_coef[PIX_OUT_WIDTH-1];
  assign w_mag = w_neg ? -i_coef : i_coef;
  assign w_rnd = RW'((PW'(w_mag) * PW'(i_recip) + PW'(32768)) >> 16);
  // negative side may reach magnitude 2^(QUANT_WIDTH-1) before clamping
  assign o_q = !w_neg ? (w_rnd > MAXP ? MAXP[QUANT_WIDTH-1:0] : w_rnd[QUANT_WIDTH-1:0])
                      : (w_rnd > MAXN ? MAXN[QUANT_WIDTH-1:0] : -w_rnd[QUANT_WIDTH-1:0]);
endmodule

// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag: quantizes DCT rows into a ping-pong block buffer and streams them in zigzag order.
// Optional DCT_QUANT_CHROMA_EN adds table_sel_i for a per-bank luma/chroma table choice.
module dct_quant_zigzag
  import jpeg_pkg::*;
#(
  parameter int PIX_OUT_WIDTH = 32,
  parameter int QUANT_WIDTH = 12,
  parameter int RECIP_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       row_vld_i,
  input  logic                       row_first_i,
`ifdef DCT_QUANT_CHROMA_EN
  input  logic                       table_sel_i,
`endif
  input  logic [PIX_OUT_WIDTH*8-1:0] data_in_i,
  output logic [QUANT_WIDTH-1:0]     q_data_o,
  output logic                       q_vld_o,
  input  logic                       q_rdy_i,
  output logic                       q_sof_o,
  output logic                       q_eob_o,
  output logic                       overflow_o
);
  logic                       r_in_vld, r_in_first;
  logic [PIX_OUT_WIDTH*8-1:0] r_in_data;
  wstate_t                    r_wstate, w_wstate_nxt;
  rstate_t                    r_rstate, w_rstate_nxt;
  logic [2:0]                 r_row, w_row;
  bank_t                      r_wbank, r_rbank, w_pick, w_wbank;
  idx_t                       r_k;
  logic [1:0]                 r_full, w_rfree, w_avail, w_set;
  logic                       r_ovf, w_ld, w_start, w_drop, w_we, w_done, w_sel;
  logic [QUANT_WIDTH-1:0]     r_q_data;
  logic                       r_q_vld, r_q_sof, r_q_eob;
  logic [QUANT_WIDTH-1:0]     r_mem [2][64];
  logic [RECIP_WIDTH-1:0]     w_recip [8];
  logic [QUANT_WIDTH-1:0]     w_q [8];
  assign w_ld = r_rstate == R_STREAM && (!r_q_vld || q_rdy_i);
  // a bank released by the reader this cycle is already available to the writer
  always_comb begin
    w_rfree = 2'b00;
    w_rfree[r_rbank] = w_ld && r_k == 6'd63;
  end
  assign w_avail = ~r_full | w_rfree;
  assign w_pick = w_avail[0] ? 1'b0 : 1'b1;
  assign w_start = r_in_vld && r_in_first && r_wstate == W_IDLE && |w_avail;
  assign w_drop = r_in_vld && r_in_first && r_wstate == W_IDLE && !(|w_avail);
  assign w_we = w_start || (r_wstate == W_ROWS && r_in_vld);
  assign w_wbank = r_wstate == W_IDLE ? w_pick : r_wbank;
  assign w_row = r_in_first ? 3'd0 : r_row;
  assign w_done = r_wstate == W_ROWS && r_in_vld && !r_in_first && r_row == 3'd7;
  assign w_set = w_done ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  always_comb begin
    w_wstate_nxt = w_start ? W_ROWS : w_done ? W_IDLE : r_wstate;
    w_rstate_nxt = r_rstate == R_IDLE ? (|r_full ? R_STREAM : R_IDLE)
                 : (w_ld && r_k == 6'd63 && !r_full[~r_rbank]) ? R_IDLE : R_STREAM;
  end
`ifdef DCT_QUANT_CHROMA_EN
  logic       r_in_sel;
  logic [1:0] r_tsel;
  always_ff @(posedge clk_i) begin
    r_in_sel <= table_sel_i;
    if (w_we && r_in_first) r_tsel[w_wbank] <= r_in_sel;
  end
  assign w_sel = r_in_first ? r_in_sel : r_tsel[w_wbank];
`else
  assign w_sel = 1'b0;
`endif
  for (genvar c = 0; c < 8; c++) begin : g_q
    logic [5:0] w_a;
    assign w_a = {w_row, 3'(c)};
    assign w_recip[c] = RECIP_WIDTH'(w_sel ? RECIP_CHROMA[w_a] : RECIP_LUMA[w_a]);
    quant_coef #(.PIX_OUT_WIDTH(PIX_OUT_WIDTH), .QUANT_WIDTH(QUANT_WIDTH), .RECIP_WIDTH(RECIP_WIDTH)) u_q (
      .i_coef (r_in_data[(7-c)*PIX_OUT_WIDTH +: PIX_OUT_WIDTH]),
      .i_recip(w_recip[c]),
      .o_q    (w_q[c])
    );
  end
  always_ff @(posedge clk_i) begin
    r_in_data <= data_in_i;
    if (w_we)
      for (int c = 0; c < 8; c++) r_mem[w_wbank][{w_row, 3'(c)}] <= w_q[c];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in_vld <= 1'b0;
      r_in_first <= 1'b0;
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_row <= 3'd0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      r_k <= 6'd0;
      r_full <= 2'b00;
      r_ovf <= 1'b0;
      r_q_data <= '0;
      r_q_vld <= 1'b0;
      r_q_sof <= 1'b0;
      r_q_eob <= 1'b0;
    end else begin
      r_in_vld <= row_vld_i;
      r_in_first <= row_first_i;
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      if (w_we) r_row <= w_row + 3'd1;
      if (w_start) r_wbank <= w_pick;
      r_ovf <= r_ovf | w_drop;
      r_full <= (r_full & ~w_rfree) | w_set;
      if (r_rstate == R_IDLE && |r_full) begin
        r_rbank <= r_full[0] ? 1'b0 : 1'b1;
        r_k <= 6'd0;
      end
      if (w_ld) begin
        r_q_data <= r_mem[r_rbank][ZIGZAG[r_k]];
        r_q_vld <= 1'b1;
        r_q_sof <= r_k == 6'd0;
        r_q_eob <= r_k == 6'd63;
        r_k <= r_k + 6'd1;
        if (r_k == 6'd63) r_rbank <= ~r_rbank;
      end else if (q_rdy_i) r_q_vld <= 1'b0;
    end
  end
  assign q_data_o = r_q_data;
  assign q_vld_o = r_q_vld;
  assign q_sof_o = r_q_sof;
  assign q_eob_o = r_q_eob;
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_dct_quant_zigzag.sv
// tb_dct_quant_zigzag: directed self-checking bench for dct_quant_zigzag (default luma build).
module tb_dct_quant_zigzag;
  logic clk = 1'b0, rst_i = 1'b1, row_vld_i = 1'b0, row_first_i = 1'b0, q_rdy_i = 1'b0;
  logic [255:0] data_in_i = '0;
  logic [11:0] q_data_o;
  logic q_vld_o, q_sof_o, q_eob_o, overflow_o;
  int errors = 0, checks = 0;
  logic signed [31:0] blk [64];
  logic [11:0] got [128];
  logic gsof [128], geob [128];
  always #5 clk = ~clk;
  dct_quant_zigzag dut (
    .clk_i(clk), .rst_i(rst_i), .row_vld_i(row_vld_i), .row_first_i(row_first_i),
    .data_in_i(data_in_i), .q_data_o(q_data_o), .q_vld_o(q_vld_o), .q_rdy_i(q_rdy_i),
    .q_sof_o(q_sof_o), .q_eob_o(q_eob_o), .overflow_o(overflow_o)
  );
  task automatic clear_blk;
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask
  task automatic send_block;
    for (int r = 0; r < 8; r++) begin
      row_vld_i = 1'b1;
      row_first_i = (r == 0);
      for (int c = 0; c < 8; c++) data_in_i[(7-c)*32 +: 32] = blk[r*8+c];
      @(posedge clk); #1;
    end
    row_vld_i = 1'b0;
    row_first_i = 1'b0;
  endtask
  task automatic rx(input int n_exp, input int budget, output int n_got, output int lat, output int span);
    n_got = 0; lat = -1; span = 0;
    for (int cyc = 0; cyc < budget && n_got < n_exp; cyc++) begin
      if (q_vld_o) begin
        if (lat < 0) lat = cyc;
        got[n_got] = q_data_o; gsof[n_got] = q_sof_o; geob[n_got] = q_eob_o;
        n_got++;
      end
      if (lat >= 0) span++;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", q_vld_o); end
    checks++; if (q_data_o !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", q_data_o); end
    checks++; if (q_sof_o !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", q_sof_o); end
    checks++; if (q_eob_o !== 1'b0) begin errors++; $display("FAIL reset_eob: got %b expected 0", q_eob_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_zero;
    int n, lat, span, nz, ns, ne;
    clear_blk();
    q_rdy_i = 1'b1;
    send_block();
    rx(64, 300, n, lat, span);
    nz = 0; ns = 0; ne = 0;
    for (int i = 0; i < 64; i++) begin
      if (got[i] != 12'd0) nz++;
      if (gsof[i]) ns++;
      if (geob[i]) ne++;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL zero_count: got %0d expected 64", n); end
    checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency: got %0d expected 3", lat); end
    checks++; if (nz != 0) begin errors++; $display("FAIL zero_data: got %0d nonzero expected 0", nz); end
    checks++; if (gsof[0] !== 1'b1 || ns != 1) begin errors++; $display("FAIL zero_sof: got first=%b total=%0d expected 1/1", gsof[0], ns); end
    checks++; if (geob[63] !== 1'b1 || ne != 1) begin errors++; $display("FAIL zero_eob: got last=%b total=%0d expected 1/1", geob[63], ne); end
  endtask
  task automatic test_dc;
    int n, lat, span, nz;
    clear_blk();
    blk[0] = 1024;
    send_block();
    rx(64, 300, n, lat, span);
    nz = 0;
    for (int i = 1; i < 64; i++) if (got[i] != 12'd0) nz++;
    checks++; if (n != 64) begin errors++; $display("FAIL dc_count: got %0d expected 64", n); end
    checks++; if (got[0] !== 12'd64) begin errors++; $display("FAIL dc_value: got %0d expected 64", $signed(got[0])); end
    checks++; if (nz != 0) begin errors++; $display("FAIL dc_ac_zero: got %0d nonzero expected 0", nz); end
  endtask
  task automatic test_ac;
    int n, lat, span;
    clear_blk();
    blk[1] = -17; blk[8] = 5; blk[9] = 100; blk[5] = -60; blk[63] = -200;
    send_block();
    rx(64, 300, n, lat, span);
    checks++; if (n != 64) begin errors++; $display("FAIL ac_count: got %0d expected 64", n); end
    checks++; if (got[1] !== 12'hffe) begin errors++; $display("FAIL ac_zz1: got %0d expected -2", $signed(got[1])); end
    checks++; if (got[2] !== 12'd0) begin errors++; $display("FAIL ac_zz2: got %0d expected 0", $signed(got[2])); end
    checks++; if (got[4] !== 12'd8) begin errors++; $display("FAIL ac_zz4: got %0d expected 8", $signed(got[4])); end
    checks++; if (got[15] !== 12'hfff) begin errors++; $display("FAIL ac_zz15: got %0d expected -1", $signed(got[15])); end
    checks++; if (got[63] !== 12'hffe) begin errors++; $display("FAIL ac_zz63: got %0d expected -2", $signed(got[63])); end
  endtask
  task automatic test_saturate;
    int n, lat, span;
    int vin [4] = '{1 << 20, -(1 << 20), 32760, -32760};
    logic [11:0] vexp [4] = '{12'h7ff, 12'h800, 12'h7ff, 12'h800};
    for (int t = 0; t < 4; t++) begin
      clear_blk();
      blk[0] = vin[t];
      send_block();
      rx(64, 300, n, lat, span);
      checks++;
      if (n != 64 || got[0] !== vexp[t])
        begin errors++; $display("FAIL sat_%0d: got %0d (n=%0d) expected %0d", t, $signed(got[0]), n, $signed(vexp[t])); end
    end
  endtask
  task automatic test_back_to_back;
    int n, lat, span, extra;
    logic [11:0] held;
    q_rdy_i = 1'b0;
    clear_blk(); blk[0] = 1024; send_block();
    clear_blk(); blk[0] = 512; send_block();
    clear_blk(); blk[0] = 256; send_block();
    held = q_data_o;
    repeat (76) @(posedge clk);
    #1;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b expected 1", overflow_o); end
    checks++; if (q_vld_o !== 1'b1 || q_sof_o !== 1'b1) begin errors++; $display("FAIL b2b_stall_flags: got vld=%b sof=%b expected 1/1", q_vld_o, q_sof_o); end
    checks++; if (q_data_o !== held || held !== 12'd64) begin errors++; $display("FAIL b2b_stall_hold: got %0d then %0d expected 64", $signed(held), $signed(q_data_o)); end
    q_rdy_i = 1'b1;
    rx(128, 400, n, lat, span);
    checks++; if (n != 128) begin errors++; $display("FAIL b2b_count: got %0d expected 128", n); end
    checks++; if (span != 128) begin errors++; $display("FAIL b2b_gapless: got %0d cycles expected 128", span); end
    checks++; if (got[0] !== 12'd64 || got[64] !== 12'd32) begin errors++; $display("FAIL b2b_dc: got %0d/%0d expected 64/32", $signed(got[0]), $signed(got[64])); end
    checks++; if (gsof[64] !== 1'b1 || geob[63] !== 1'b1 || geob[127] !== 1'b1) begin errors++; $display("FAIL b2b_markers: got sof64=%b eob63=%b eob127=%b expected 1/1/1", gsof[64], geob[63], geob[127]); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (q_vld_o) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_drained: got %0d extra valid cycles expected 0", extra); end
  endtask
  task automatic test_reset_mid;
    int n, lat, span;
    bit found;
    clear_blk(); blk[0] = 1024; blk[21] = 570;
    q_rdy_i = 1'b1;
    send_block();
    n = 0; found = 0;
    for (int cyc = 0; cyc < 300 && !found; cyc++) begin
      if (q_vld_o) begin
        if (n == 30) found = 1;
        else n++;
      end
      if (!found) begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach30: got index %0d expected 30", n); end
    checks++; if (q_data_o !== 12'd10) begin errors++; $display("FAIL mid_zz30: got %0d expected 10", $signed(q_data_o)); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (q_vld_o !== 1'b0 || q_sof_o !== 1'b0 || q_eob_o !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got vld=%b sof=%b eob=%b expected 0/0/0", q_vld_o, q_sof_o, q_eob_o); end
    checks++; if (q_data_o !== 12'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL mid_rst_data: got %0d ovf=%b expected 0/0", q_data_o, overflow_o); end
    rst_i = 1'b0;
    @(posedge clk); #1;
    clear_blk(); blk[0] = 48; blk[1] = -17; blk[8] = 5;
    send_block();
    rx(64, 300, n, lat, span);
    checks++; if (n != 64 || lat != 3) begin errors++; $display("FAIL mid_fresh_count: got n=%0d lat=%0d expected 64/3", n, lat); end
    checks++; if (got[0] !== 12'd3 || gsof[0] !== 1'b1) begin errors++; $display("FAIL mid_fresh_dc: got %0d sof=%b expected 3/1", $signed(got[0]), gsof[0]); end
    checks++; if (got[1] !== 12'hffe || got[2] !== 12'd0) begin errors++; $display("FAIL mid_fresh_ac: got %0d/%0d expected -2/0", $signed(got[1]), $signed(got[2])); end
    checks++; if (geob[63] !== 1'b1) begin errors++; $display("FAIL mid_fresh_eob: got %b expected 1", geob[63]); end
  endtask
  initial begin
    test_reset();
    test_zero();
    test_dc();
    test_ac();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
